key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel push-button debouncer with press/release/auto-repeat pulses
//
// Each raw active-low button is passed through a two-flop synchronizer and
// then through its own four-state debounce FSM. An accepted press or release
// produces a one-cycle pulse. When auto-repeat is enabled, a held key also
// produces repeat pulses.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   key_n       raw buttons, active-low, asynchronous and bouncing
//   key_level   debounced state, 1 = held
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   key_repeat  one-cycle auto-repeat pulse while held (0 when disabled)
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        HELD,
        CONFIRM_RELEASE
    } state_t;

    // Synchronizer stores the inverted (active-high) level so that the reset
    // value 0 means "released".
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nxt;
        logic          rfirst;
        logic          rfirst_nxt;
        logic          press_nxt;
        logic          release_nxt;
        logic          repeat_nxt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        logic          s;

        assign s = sync2[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                rfirst    <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                rcnt      <= rcnt_nxt;
                rfirst    <= rfirst_nxt;
                // Level is registered from the next state so that it rises on
                // the same edge as the press pulse.
                level_q   <= (state_nxt == HELD) || (state_nxt == CONFIRM_RELEASE);
                press_q   <= press_nxt;
                release_q <= release_nxt;
                repeat_q  <= repeat_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            rcnt_nxt    = rcnt;
            rfirst_nxt  = rfirst;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            repeat_nxt  = 1'b0;

            case (state)
                IDLE: begin
                    if (s) begin
                        state_nxt = CONFIRM_PRESS;
                        cnt_nxt   = '0;
                    end
                end
                CONFIRM_PRESS: begin
                    if (!s) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt  = HELD;
                        press_nxt  = 1'b1;
                        rcnt_nxt   = '0;
                        rfirst_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nxt = CONFIRM_RELEASE;
                        cnt_nxt   = '0;
                    end
                end
                CONFIRM_RELEASE: begin
                    if (s) begin
                        state_nxt = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // Repeat timer runs across HELD and CONFIRM_RELEASE so a short
            // release glitch does not disturb the cadence. It is suppressed on
            // the edge that accepts the release, and reloads instead of
            // wrapping so it can never emit a stray pulse.
            if ((state == HELD || state == CONFIRM_RELEASE) && state_nxt != IDLE) begin
                if (rcnt == (rfirst ? RDLY_LAST : RPER_LAST)) begin
                    repeat_nxt = (REPEAT_EN != 0);
                    rcnt_nxt   = '0;
                    rfirst_nxt = 1'b0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_repeat[i]  = repeat_q;
    end

endmodule
